// File: rtl/country_sensor_conditioner.sv
// Conditions the country-road loop detector into a vehicle-waiting request `x`:
// two-flop synchroniser, debounce filter, arrival pulse and a saturating queue counter cleared on green.
module country_sensor_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             start,
  input  logic             raw_sense,
  input  logic [2:0]       country,
  output logic             x,
  output logic [CNT_W-1:0] wait_count,
  output logic             arrival
);

  localparam int              FW   = $clog2(DEBOUNCE + 1);
  localparam logic [FW-1:0]   FLIM = FW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] WMAX = '1;

  logic          s1;
  logic          s;
  logic          db;
  logic [FW-1:0] fcnt;

  logic             accept;
  logic             rise;
  logic             green;
  logic [CNT_W-1:0] wait_next;

  // The new level is taken on the DEBOUNCE-th consecutive disagreeing edge.
  assign accept = (s != db) && (fcnt == FLIM);
  assign rise   = accept && s;
  assign green  = (country == 3'b001);

  always_comb begin
    wait_next = wait_count;
    if (green) begin
      wait_next = '0;
    end else if (rise && (wait_count != WMAX)) begin
      wait_next = wait_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      s1         <= 1'b0;
      s          <= 1'b0;
      db         <= 1'b0;
      fcnt       <= '0;
      arrival    <= 1'b0;
      wait_count <= '0;
      x          <= 1'b0;
    end else begin
      s1 <= raw_sense;
      s  <= s1;
      if (s == db) begin
        fcnt <= '0;
      end else if (fcnt == FLIM) begin
        db   <= s;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
      arrival    <= rise;
      wait_count <= wait_next;
      // Derived from the next count so x and wait_count always agree.
      x          <= (wait_next != '0);
    end
  end

endmodule

// File: tb/tb_country_sensor_conditioner.sv
// Bench for country_sensor_conditioner: table-driven segments, hand-written corner
// sequences, then random stimulus against a sample-history reference model.
module tb_country_sensor_conditioner;

  localparam int DEB  = 4;
  localparam int CW   = 4;
  localparam int WMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          start = 1'b1;
  logic          raw_sense = 1'b0;
  logic [2:0]    country = 3'b100;
  logic          x;
  logic [CW-1:0] wait_count;
  logic          arrival;

  int errors = 0;
  int checks = 0;

  country_sensor_conditioner #(.DEBOUNCE(DEB), .CNT_W(CW)) dut (
    .clk(clk), .start(start), .raw_sense(raw_sense), .country(country),
    .x(x), .wait_count(wait_count), .arrival(arrival)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples since the last reset release. The filtered level
  // flips when the synchronised samples at the last DEB edges all disagree with it.
  bit   smp[$];
  logic m_db;
  int   m_wc;
  logic m_x;
  logic m_arr;

  function automatic void model_reset();
    smp.delete();
    m_db  = 1'b0;
    m_wc  = 0;
    m_x   = 1'b0;
    m_arr = 1'b0;
  endfunction

  function automatic void model_edge();
    int k;
    bit all_diff;
    bit sv;
    bit rise;
    if (!start) begin
      model_reset();
      return;
    end
    smp.push_back(raw_sense);
    k = smp.size() - 1;
    all_diff = 1'b1;
    for (int i = 0; i < DEB; i++) begin
      int e;
      e = k - i;
      if (e < 0) begin
        all_diff = 1'b0;
      end else begin
        sv = (e >= 2) ? smp[e-2] : 1'b0;
        if (sv == m_db) all_diff = 1'b0;
      end
    end
    rise = all_diff && !m_db;
    if (all_diff) m_db = ~m_db;
    m_arr = rise;
    if (country == 3'b001) m_wc = 0;
    else if (rise && m_wc < WMAX) m_wc = m_wc + 1;
    m_x = (m_wc != 0);
  endfunction

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_vehicle(output int arrs);
    arrs = 0;
    raw_sense = 1'b1;
    repeat (10) begin tick(); if (arrival) arrs++; end
    raw_sense = 1'b0;
    repeat (10) begin tick(); if (arrival) arrs++; end
  endtask

  typedef struct {
    logic       raw;
    logic [2:0] cty;
    int         cycles;
    int         exp_arr;
    int         exp_wc;
    logic       exp_x;
  } seg_t;

  seg_t segs[$];

  initial begin
    int arrs;
    int total;
    int raw_hold;
    int cty_hold;
    int r;

    segs.push_back('{1'b0, 3'b100, 10, 0, 1, 1'b1});
    segs.push_back('{1'b0, 3'b001,  1, 0, 0, 1'b0});
    segs.push_back('{1'b1, 3'b100, 10, 1, 1, 1'b1});
    segs.push_back('{1'b0, 3'b100, 10, 0, 1, 1'b1});
    segs.push_back('{1'b1, 3'b100,  3, 0, 1, 1'b1});
    segs.push_back('{1'b0, 3'b100,  1, 0, 1, 1'b1});
    segs.push_back('{1'b1, 3'b100,  3, 0, 1, 1'b1});
    segs.push_back('{1'b0, 3'b100, 10, 0, 1, 1'b1});
    segs.push_back('{1'b1, 3'b100, 10, 1, 2, 1'b1});
    segs.push_back('{1'b0, 3'b100, 10, 0, 2, 1'b1});
    segs.push_back('{1'b1, 3'b100, 10, 1, 3, 1'b1});
    segs.push_back('{1'b0, 3'b100, 10, 0, 3, 1'b1});
    segs.push_back('{1'b0, 3'b010, 10, 0, 3, 1'b1});
    segs.push_back('{1'b0, 3'b001,  1, 0, 0, 1'b0});
    segs.push_back('{1'b1, 3'b001, 10, 1, 0, 1'b0});
    segs.push_back('{1'b0, 3'b001, 10, 0, 0, 1'b0});
    segs.push_back('{1'b1, 3'b011, 10, 1, 1, 1'b1});
    segs.push_back('{1'b0, 3'b111, 10, 0, 1, 1'b1});
    segs.push_back('{1'b0, 3'b000, 10, 0, 1, 1'b1});
    segs.push_back('{1'b0, 3'b001,  1, 0, 0, 1'b0});

    // Reset held with a vehicle present, then release and time the first arrival.
    raw_sense = 1'b1;
    country   = 3'b100;
    #2 start  = 1'b0;
    model_reset();
    #1;
    chk("reset x", x, 0);
    chk("reset wait_count", wait_count, 0);
    chk("reset arrival", arrival, 0);
    repeat (3) begin
      tick();
      chk("reset held outputs", {x, wait_count, arrival}, 0);
    end
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) chk("release latency x low", x, 0);
    end
    chk("release x rises at 6th edge", x, 1);
    chk("release wait_count", wait_count, 1);
    chk("release arrival", arrival, 1);
    tick();
    chk("arrival one cycle", arrival, 0);
    $display("reset/release sequence: x=%0d wait_count=%0d", x, wait_count);

    foreach (segs[n]) begin
      raw_sense = segs[n].raw;
      country   = segs[n].cty;
      arrs = 0;
      repeat (segs[n].cycles) begin tick(); if (arrival) arrs++; end
      chk($sformatf("seg%0d arrivals", n), arrs, segs[n].exp_arr);
      chk($sformatf("seg%0d wait_count", n), wait_count, segs[n].exp_wc);
      chk($sformatf("seg%0d x", n), x, segs[n].exp_x);
      $display("seg %0d: raw=%0d country=%b cycles=%0d arrivals=%0d wait_count=%0d x=%0d",
               n, segs[n].raw, segs[n].cty, segs[n].cycles, arrs, wait_count, x);
    end

    // Saturation: 16 vehicles on an empty queue.
    country = 3'b100;
    total = 0;
    repeat (16) begin run_vehicle(arrs); total += arrs; end
    chk("sat arrivals", total, 16);
    chk("sat wait_count", wait_count, WMAX);
    chk("sat x", x, 1);
    $display("saturation: arrivals=%0d wait_count=%0d", total, wait_count);

    // Arrival qualifying on the same edge that green begins.
    raw_sense = 1'b1;
    repeat (5) tick();
    chk("simul pre arrival", arrival, 0);
    chk("simul pre wait_count", wait_count, WMAX);
    country = 3'b001;
    tick();
    chk("simul arrival", arrival, 1);
    chk("simul wait_count", wait_count, 0);
    chk("simul x", x, 0);
    raw_sense = 1'b0;
    country   = 3'b100;
    repeat (10) tick();
    $display("simultaneous green/arrival: wait_count=%0d x=%0d", wait_count, x);

    // Reset mid-cycle with two queued vehicles and a half-counted debounce.
    repeat (2) run_vehicle(arrs);
    chk("midreset queued", wait_count, 2);
    raw_sense = 1'b1;
    repeat (4) tick();
    chk("midreset pending", {wait_count, arrival}, {4'd2, 1'b0});
    #2 start = 1'b0;
    model_reset();
    #1;
    chk("midreset async clear", {x, wait_count, arrival}, 0);
    repeat (2) begin
      tick();
      chk("midreset held", {x, wait_count, arrival}, 0);
    end
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i < 6) chk("midreset requalify x low", x, 0);
    end
    chk("midreset requalify x", x, 1);
    chk("midreset requalify wait_count", wait_count, 1);
    chk("midreset requalify arrival", arrival, 1);
    $display("reset during operation: wait_count=%0d x=%0d", wait_count, x);

    // Random stimulus against the reference model.
    raw_hold = 0;
    cty_hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (raw_hold == 0) begin
        raw_sense = 1'($urandom_range(0, 1));
        raw_hold  = $urandom_range(1, 12);
      end
      raw_hold--;
      if (cty_hold == 0) begin
        r = $urandom_range(0, 9);
        country  = (r == 0) ? 3'b001 : (r == 1) ? 3'b010 : (r == 2) ? 3'b011 : 3'b100;
        cty_hold = $urandom_range(5, 40);
      end
      cty_hold--;
      if ($urandom_range(0, 299) == 0) begin
        start = 1'b0;
        model_reset();
      end else begin
        start = 1'b1;
      end
      tick();
      chk($sformatf("rand c%0d {x,wait_count,arrival}", c),
          {x, wait_count, arrival}, {m_x, 4'(m_wc), m_arr});
    end
    $display("random phase: final wait_count=%0d model=%0d", wait_count, m_wc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
